// File: rtl/bp_lce_req_arbiter.sv
// bp_lce_req_arbiter
// Round-robin arbiter that shares one LCE-to-CCE burst request port among
// num_req_p request sources. A grant is held for a whole message: the header,
// then every data beat through last. Header width is supplied as a parameter
// and stands in for the width derived from the processor configuration.
// Optional feature macro: BP_LCE_REQ_ARB_WATCHDOG_EN adds a sticky watchdog_o
// that fires after watchdog_limit_p stalled cycles inside a locked data burst.
module bp_lce_req_arbiter #(
    parameter int num_req_p              = 2,
    parameter int lce_req_header_width_p = 64,
    parameter int fill_width_p           = 64
`ifdef BP_LCE_REQ_ARB_WATCHDOG_EN
    , parameter int watchdog_limit_p     = 1024
`endif
    , localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic [num_req_p*lce_req_header_width_p-1:0] req_header_i,
    input  logic [num_req_p-1:0]                       req_header_v_i,
    output logic [num_req_p-1:0]                       req_header_ready_and_o,
    input  logic [num_req_p-1:0]                       req_has_data_i,
    input  logic [num_req_p*fill_width_p-1:0]          req_data_i,
    input  logic [num_req_p-1:0]                       req_data_v_i,
    output logic [num_req_p-1:0]                       req_data_ready_and_o,
    input  logic [num_req_p-1:0]                       req_last_i,
    output logic [lce_req_header_width_p-1:0]          lce_req_header_o,
    output logic                                       lce_req_header_v_o,
    input  logic                                       lce_req_header_ready_and_i,
    output logic                                       lce_req_has_data_o,
    output logic [fill_width_p-1:0]                    lce_req_data_o,
    output logic                                       lce_req_data_v_o,
    input  logic                                       lce_req_data_ready_and_i,
    output logic                                       lce_req_last_o,
    output logic [lg_num_req_lp-1:0]                   grant_o,
    output logic                                       busy_o
`ifdef BP_LCE_REQ_ARB_WATCHDOG_EN
    , output logic                                     watchdog_o
`endif
);

    typedef enum logic {e_idle, e_data} state_e;

    state_e                   state;
    logic [lg_num_req_lp-1:0] rr_ptr;
    logic [lg_num_req_lp-1:0] grant_r;
    logic [lg_num_req_lp-1:0] sel;
    logic [lg_num_req_lp-1:0] cand;
    logic                     found;
    logic                     header_hs;
    logic                     data_hs;

    // Requester index (base + offs) modulo num_req_p; offs is below num_req_p.
    function automatic logic [lg_num_req_lp-1:0] wrap_add(
        input logic [lg_num_req_lp-1:0] base,
        input int                       offs
    );
        int s;
        s = int'(base) + offs;
        if (s >= num_req_p) s = s - num_req_p;
        return lg_num_req_lp'(s);
    endfunction

    // Round-robin search for the first valid header starting at rr_ptr.
    always_comb begin
        sel   = rr_ptr;
        cand  = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            cand = wrap_add(rr_ptr, i);
            if (!found && req_header_v_i[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    // Steer the shared port: headers pass through in e_idle, beats in e_data.
    // Everything is forced low while reset is held.
    always_comb begin
        lce_req_header_o       = '0;
        lce_req_header_v_o     = 1'b0;
        lce_req_has_data_o     = 1'b0;
        req_header_ready_and_o = '0;
        lce_req_data_o         = '0;
        lce_req_data_v_o       = 1'b0;
        lce_req_last_o         = 1'b0;
        req_data_ready_and_o   = '0;
        grant_o                = '0;
        busy_o                 = 1'b0;
        if (!reset_i) begin
            if (state == e_idle) begin
                lce_req_header_o            = req_header_i[int'(sel)*lce_req_header_width_p +: lce_req_header_width_p];
                lce_req_has_data_o          = req_has_data_i[sel];
                lce_req_header_v_o          = |req_header_v_i;
                req_header_ready_and_o[sel] = lce_req_header_ready_and_i;
                grant_o                     = sel;
            end else begin
                lce_req_data_o                = req_data_i[int'(grant_r)*fill_width_p +: fill_width_p];
                lce_req_data_v_o              = req_data_v_i[grant_r];
                lce_req_last_o                = req_last_i[grant_r];
                req_data_ready_and_o[grant_r] = lce_req_data_ready_and_i;
                busy_o                        = 1'b1;
                grant_o                       = grant_r;
            end
        end
    end

    assign header_hs = lce_req_header_v_o & lce_req_header_ready_and_i;
    assign data_hs   = lce_req_data_v_o & lce_req_data_ready_and_i;

    // Lock/release FSM; rr_ptr advances past a requester once its message ends.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= e_idle;
            rr_ptr  <= '0;
            grant_r <= '0;
        end else begin
            case (state)
                e_idle: begin
                    if (header_hs) begin
                        if (lce_req_has_data_o) begin
                            grant_r <= sel;
                            state   <= e_data;
                        end else begin
                            rr_ptr <= wrap_add(sel, 1);
                        end
                    end
                end
                e_data: begin
                    if (data_hs && lce_req_last_o) begin
                        rr_ptr <= wrap_add(grant_r, 1);
                        state  <= e_idle;
                    end
                end
                default: state <= e_idle;
            endcase
        end
    end

`ifdef BP_LCE_REQ_ARB_WATCHDOG_EN
    localparam int wd_w_lp = $clog2(watchdog_limit_p + 1);

    logic [wd_w_lp-1:0] stall_cnt;

    // Count stalled burst cycles; watchdog_o latches once the limit is reached.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt  <= '0;
            watchdog_o <= 1'b0;
        end else if (state == e_data && !data_hs) begin
            if (stall_cnt != wd_w_lp'(watchdog_limit_p)) stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == wd_w_lp'(watchdog_limit_p - 1)) watchdog_o <= 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_bp_lce_req_arbiter.sv
// Directed bench for bp_lce_req_arbiter with three requesters: reset,
// round-robin rotation, wrap priority, burst lock, backpressure, async reset.
module tb_bp_lce_req_arbiter;

    localparam int N  = 3;
    localparam int HW = 16;
    localparam int FW = 16;

    logic            clk;
    logic            reset_i;
    logic [N*HW-1:0] req_header;
    logic [N-1:0]    req_header_v;
    logic [N-1:0]    req_header_ready;
    logic [N-1:0]    req_has_data;
    logic [N*FW-1:0] req_data;
    logic [N-1:0]    req_data_v;
    logic [N-1:0]    req_data_ready;
    logic [N-1:0]    req_last;
    logic [HW-1:0]   hdr_o;
    logic            hdr_v_o;
    logic            hdr_ready_i;
    logic            has_data_o;
    logic [FW-1:0]   data_o;
    logic            data_v_o;
    logic            data_ready_i;
    logic            last_o;
    logic [1:0]      grant;
    logic            busy;
`ifdef BP_LCE_REQ_ARB_WATCHDOG_EN
    logic            watchdog;
`endif

    int tests = 0;
    int fails = 0;

    bp_lce_req_arbiter #(
        .num_req_p              (N),
        .lce_req_header_width_p (HW),
        .fill_width_p           (FW)
`ifdef BP_LCE_REQ_ARB_WATCHDOG_EN
        , .watchdog_limit_p     (16)
`endif
    ) dut (
        .clk_i                      (clk),
        .reset_i                    (reset_i),
        .req_header_i               (req_header),
        .req_header_v_i             (req_header_v),
        .req_header_ready_and_o     (req_header_ready),
        .req_has_data_i             (req_has_data),
        .req_data_i                 (req_data),
        .req_data_v_i               (req_data_v),
        .req_data_ready_and_o       (req_data_ready),
        .req_last_i                 (req_last),
        .lce_req_header_o           (hdr_o),
        .lce_req_header_v_o         (hdr_v_o),
        .lce_req_header_ready_and_i (hdr_ready_i),
        .lce_req_has_data_o         (has_data_o),
        .lce_req_data_o             (data_o),
        .lce_req_data_v_o           (data_v_o),
        .lce_req_data_ready_and_i   (data_ready_i),
        .lce_req_last_o             (last_o),
        .grant_o                    (grant),
        .busy_o                     (busy)
`ifdef BP_LCE_REQ_ARB_WATCHDOG_EN
        , .watchdog_o               (watchdog)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hdr(input int r, input logic [HW-1:0] h, input logic v, input logic hd);
        req_header[r*HW +: HW] = h;
        req_header_v[r]        = v;
        req_has_data[r]        = hd;
    endtask

    task automatic set_beat(input int r, input logic [FW-1:0] d, input logic v, input logic l);
        req_data[r*FW +: FW] = d;
        req_data_v[r]        = v;
        req_last[r]          = l;
    endtask

    initial begin
        int exp_src [4];
        exp_src = '{0, 1, 0, 1};

        reset_i      = 1'b1;
        req_header   = '0;
        req_header_v = '0;
        req_has_data = '0;
        req_data     = '0;
        req_data_v   = '0;
        req_last     = '0;
        hdr_ready_i  = 1'b0;
        data_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_hdr_ready", 64'(req_header_ready), 0);
        reset_i = 1'b0;
        #1;
        chk("post_rst_grant", 64'(grant), 0);
        chk("post_rst_hdr_v", 64'(hdr_v_o), 0);

        // Round robin: requesters 0 and 1 stream no-data headers.
        set_hdr(0, 16'hA000, 1'b1, 1'b0);
        set_hdr(1, 16'hB001, 1'b1, 1'b0);
        hdr_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_grant", 64'(grant), 64'(exp_src[k]));
            chk("rr_hdr", 64'(hdr_o), (exp_src[k] == 0) ? 64'hA000 : 64'hB001);
            chk("rr_ready", 64'(req_header_ready), 64'(1 << exp_src[k]));
            chk("rr_hdr_v", 64'(hdr_v_o), 1);
            tick();
        end

        // Wrap priority from rr_ptr=2; selection is not sticky.
        hdr_ready_i = 1'b0;
        #1;
        chk("wrap_grant0", 64'(grant), 0);
        set_hdr(2, 16'hE002, 1'b1, 1'b0);
        #1;
        chk("nonsticky_grant2", 64'(grant), 2);
        chk("nonsticky_hdr", 64'(hdr_o), 64'hE002);
        tick();
        set_hdr(2, 16'hE002, 1'b0, 1'b0);
        #1;
        chk("wrap_grant0_again", 64'(grant), 0);
        hdr_ready_i = 1'b1;
        #1;
        chk("wrap_ready", 64'(req_header_ready), 64'b001);
        tick();
        chk("wrap_next_grant1", 64'(grant), 1);
        tick();

        // Burst lock: requester 0 sends 8 beats, requester 1 waits with a header.
        set_hdr(0, 16'hC000, 1'b1, 1'b1);
        set_hdr(1, 16'hD001, 1'b1, 1'b0);
        set_beat(0, 16'h0100, 1'b1, 1'b0);
        set_beat(1, 16'hDEAD, 1'b1, 1'b1);
        data_ready_i = 1'b1;
        #1;
        chk("burst_hdr_grant", 64'(grant), 0);
        chk("burst_has_data", 64'(has_data_o), 1);
        chk("hdr_cycle_no_data_v", 64'(data_v_o), 0);
        chk("hdr_cycle_no_data_ready", 64'(req_data_ready), 0);
        tick();
        set_hdr(0, 16'hC000, 1'b0, 1'b0);
        #1;
        chk("lock_busy", 64'(busy), 1);
        chk("lock_hdr_v", 64'(hdr_v_o), 0);
        chk("lock_hdr_ready", 64'(req_header_ready), 0);
        for (int b = 0; b < 8; b++) begin
            set_beat(0, 16'(16'h0100 + b), 1'b1, (b == 7));
            #1;
            chk("beat_data", 64'(data_o), 64'(16'h0100 + b));
            chk("beat_ready", 64'(req_data_ready), 64'b001);
            chk("beat_last", 64'(last_o), 64'(b == 7));
            chk("beat_grant", 64'(grant), 0);
            if (b == 3) begin
                data_ready_i = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    #1;
                    chk("stall_data", 64'(data_o), 64'h0103);
                    chk("stall_ready", 64'(req_data_ready), 0);
                    chk("stall_busy", 64'(busy), 1);
                    tick();
                end
                data_ready_i = 1'b1;
                #1;
                chk("stall_release_ready", 64'(req_data_ready), 64'b001);
            end
            tick();
        end
        set_beat(0, 16'h0000, 1'b0, 1'b0);
        set_beat(1, 16'h0000, 1'b0, 1'b0);
        #1;
        chk("post_burst_busy", 64'(busy), 0);
        chk("post_burst_grant1", 64'(grant), 1);
        chk("post_burst_hdr", 64'(hdr_o), 64'hD001);
        chk("post_burst_data_v", 64'(data_v_o), 0);
        tick();
        set_hdr(1, 16'hD001, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a burst.
        set_hdr(0, 16'hC000, 1'b1, 1'b1);
        set_beat(0, 16'h01FF, 1'b1, 1'b0);
        #1;
        chk("ar_hdr_grant", 64'(grant), 0);
        tick();
        set_hdr(0, 16'hC000, 1'b0, 1'b0);
        set_hdr(2, 16'hE002, 1'b1, 1'b0);
        #1;
        chk("ar_pre_data_v", 64'(data_v_o), 1);
        chk("ar_pre_busy", 64'(busy), 1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("ar_busy", 64'(busy), 0);
        chk("ar_data_v", 64'(data_v_o), 0);
        chk("ar_data_ready", 64'(req_data_ready), 0);
        chk("ar_hdr_v", 64'(hdr_v_o), 0);
        chk("ar_hdr_ready", 64'(req_header_ready), 0);
        reset_i = 1'b0;
        set_hdr(2, 16'hE002, 1'b0, 1'b0);
        set_beat(0, 16'h0000, 1'b0, 1'b0);
        #1;
        chk("ar_rel_grant", 64'(grant), 0);
        chk("ar_rel_busy", 64'(busy), 0);
        set_hdr(1, 16'hD001, 1'b1, 1'b0);
        set_hdr(2, 16'hE002, 1'b1, 1'b0);
        #1;
        chk("ar_rr_ptr0", 64'(grant), 1);
        tick();
        set_hdr(1, 16'hD001, 1'b0, 1'b0);
        set_hdr(2, 16'hE002, 1'b0, 1'b0);

`ifdef BP_LCE_REQ_ARB_WATCHDOG_EN
        // Stall a burst for 16 cycles; watchdog latches and stays set.
        set_hdr(0, 16'hC000, 1'b1, 1'b1);
        set_beat(0, 16'h0042, 1'b1, 1'b1);
        data_ready_i = 1'b0;
        tick();
        set_hdr(0, 16'hC000, 1'b0, 1'b0);
        for (int s = 0; s < 15; s++) tick();
        chk("wd_before_limit", 64'(watchdog), 0);
        tick();
        chk("wd_at_limit", 64'(watchdog), 1);
        data_ready_i = 1'b1;
        tick();
        chk("wd_done_busy", 64'(busy), 0);
        chk("wd_sticky", 64'(watchdog), 1);
        set_beat(0, 16'h0000, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
